// File: rtl/wvb_pkg.sv
// Shared constants and state encoding for the DPRAM drain block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wvb_pkg;

  localparam int DPRAM_LINE_W   = 128;
  localparam int STREAM_W       = 16;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);

  // Drain controller states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } drain_state_t;

  // Number of 16-bit words the DPRAM can hold for a given line address width
  function automatic logic [31:0] f_capacity(input int adr_w);
    return 32'(WORDS_PER_LINE) << adr_w;
  endfunction

endpackage

// File: rtl/wvb_dpram_drain_if.sv
// 16-bit valid/ready stream from the drain toward the MCU-facing FIFO.
// Latency: n/a (wires only).
// Backpressure: m_ready from the slave; master holds m_data/m_last while stalled.
interface wvb_dpram_drain_if;

  logic [wvb_pkg::STREAM_W-1:0] m_data;
  logic                         m_valid;
  logic                         m_last;
  logic                         m_ready;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/line_serializer.sv
// Holds one 128-bit DPRAM line and presents it one 16-bit word at a time, word 0 first.
// Latency: a loaded line appears on o_data the cycle after i_load.
// Backpressure: the word index only moves on i_adv, so o_data holds while the consumer stalls.
module line_serializer
  import wvb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic [DPRAM_LINE_W-1:0] i_line,
  input  logic                    i_adv,
  output logic [WORD_IDX_W-1:0]   o_word_idx,
  output logic [STREAM_W-1:0]     o_data
);

  logic [DPRAM_LINE_W-1:0] r_line;
  logic [WORD_IDX_W-1:0]   r_word_idx;

  // Capture a fresh line once the DPRAM read data has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end
  end

  // Word pointer restarts on every new line and steps on each accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx <= '0;
    end else if (i_load) begin
      r_word_idx <= '0;
    end else if (i_adv) begin
      r_word_idx <= r_word_idx + WORD_IDX_W'(1);
    end
  end

  assign o_word_idx = r_word_idx;
  assign o_data     = r_line[STREAM_W*r_word_idx +: STREAM_W];

endmodule

// File: rtl/wvb_dpram_drain.sv
// Drains dpram_len 16-bit words from the 128-bit DPRAM onto a valid/ready stream after dpram_run.
// Latency: first word P_RD_LATENCY+2 cycles after run; P_RD_LATENCY+1 bubble cycles per line boundary.
// Backpressure: m_ready low freezes the stream word, m_last and all transfer state.
module wvb_dpram_drain
  import wvb_pkg::*;
#(
  parameter int P_DPRAM_ADR_WIDTH = 8,
  parameter int P_RD_LATENCY      = 2   // must be 1 or more
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dpram_run,
  input  logic [15:0]                  dpram_len,
  output logic                         dpram_busy,
  output logic                         dpram_mode,
  input  logic                         cfg_mode,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
  input  logic [DPRAM_LINE_W-1:0]      dpram_rd_data,
  wvb_dpram_drain_if.master            m_if,
  input  logic                         err_clr,
  output logic                         err_len,
  output logic                         err_overrun,
  output logic [31:0]                  xfer_cnt
);

  localparam logic [31:0] LP_CAP    = f_capacity(P_DPRAM_ADR_WIDTH);
  localparam int          LP_WCNT_W = $clog2(P_RD_LATENCY + 1);

  drain_state_t                 r_state;
  drain_state_t                 w_state_nxt;
  logic [15:0]                  r_rem;
  logic [LP_WCNT_W-1:0]         r_wcnt;
  logic [P_DPRAM_ADR_WIDTH-1:0] r_addr;
  logic                         r_valid;
  logic                         r_mode;
  logic                         r_err_len;
  logic                         r_err_ovr;
  logic [31:0]                  r_xfer_cnt;

  logic                         w_start;
  logic                         w_start_zero;
  logic                         w_capture;
  logic                         w_advance;
  logic                         w_line_end;
  logic                         w_finish;
  logic                         w_hs;
  logic                         w_len_over;
  logic                         w_busy;
  logic [WORD_IDX_W-1:0]        w_word_idx;
  logic [STREAM_W-1:0]          w_data;

  // The valid register is only ever set in S_STREAM, so a handshake implies that state
  assign w_hs       = r_valid && m_if.m_ready;
  assign w_len_over = 32'(dpram_len) > LP_CAP;
  assign w_busy     = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and one-cycle control strobes for the datapath
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_start_zero = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_line_end   = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dpram_run) begin
          if (dpram_len == 16'd0) begin
            w_start_zero = 1'b1;
            w_state_nxt  = S_DONE;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt == LP_WCNT_W'(P_RD_LATENCY)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          if (r_rem == 16'd1) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_word_idx == WORD_IDX_W'(WORDS_PER_LINE - 1)) begin
            w_line_end  = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Remaining-word count: clamped to capacity at start, one less per accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
    end else if (w_start) begin
      r_rem <= w_len_over ? LP_CAP[15:0] : dpram_len;
    end else if (w_hs) begin
      r_rem <= r_rem - 16'd1;
    end
  end

  // Read-latency counter: restarts whenever a new line address is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (w_start || w_line_end) begin
      r_wcnt <= '0;
    end else if ((r_state == S_WAIT) && !w_capture) begin
      r_wcnt <= r_wcnt + LP_WCNT_W'(1);
    end
  end

  // Line address: zero at start, next line after the eighth word; clamping keeps it from wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_start) begin
      r_addr <= '0;
    end else if (w_line_end) begin
      r_addr <= r_addr + P_DPRAM_ADR_WIDTH'(1);
    end
  end

  // Stream valid: raised when a line lands, dropped only on a handshake that empties the line or transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end else if (w_finish || w_line_end) begin
      r_valid <= 1'b0;
    end
  end

  // Mode bit follows the host only while idle, so the writer sees it frozen during a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_mode <= cfg_mode;
    end
  end

  // Sticky error flags; a new error in the same cycle as the clear is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_len <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      if (w_start && w_len_over) begin
        r_err_len <= 1'b1;
      end else if (err_clr) begin
        r_err_len <= 1'b0;
      end
      if (dpram_run && w_busy) begin
        r_err_ovr <= 1'b1;
      end else if (err_clr) begin
        r_err_ovr <= 1'b0;
      end
    end
  end

  // Completed-transfer counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_finish) begin
      r_xfer_cnt <= r_xfer_cnt + 32'd1;
    end
  end

  line_serializer u_line_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_capture),
    .i_line     (dpram_rd_data),
    .i_adv      (w_advance),
    .o_word_idx (w_word_idx),
    .o_data     (w_data)
  );

  assign dpram_busy    = w_busy;
  assign dpram_mode    = r_mode;
  assign dpram_rd_addr = r_addr;
  assign err_len       = r_err_len;
  assign err_overrun   = r_err_ovr;
  assign xfer_cnt      = r_xfer_cnt;

  assign m_if.m_data   = w_data;
  assign m_if.m_valid  = r_valid;
  assign m_if.m_last   = r_valid && (r_rem == 16'd1);

endmodule

// File: tb/tb_wvb_dpram_drain.sv
// Randomized bench for wvb_dpram_drain against a word-list reference model.
// Latency: checks exact handshake cycles whenever the sink is always ready.
// Backpressure: random m_ready; stream words must hold while stalled.
module tb_wvb_dpram_drain;
  import wvb_pkg::*;

  localparam int ADR_W = 8;
  localparam int LAT   = 2;
  localparam int LINES = 2 ** ADR_W;
  localparam int CAP   = WORDS_PER_LINE * LINES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dpram_run = 1'b0;
  logic [15:0]       dpram_len = '0;
  logic              dpram_busy;
  logic              dpram_mode;
  logic              cfg_mode = 1'b0;
  logic [ADR_W-1:0]  dpram_rd_addr;
  logic [127:0]      dpram_rd_data;
  logic              err_clr = 1'b0;
  logic              err_len;
  logic              err_overrun;
  logic [31:0]       xfer_cnt;

  wvb_dpram_drain_if m_if ();

  wvb_dpram_drain #(
    .P_DPRAM_ADR_WIDTH (ADR_W),
    .P_RD_LATENCY      (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dpram_run     (dpram_run),
    .dpram_len     (dpram_len),
    .dpram_busy    (dpram_busy),
    .dpram_mode    (dpram_mode),
    .cfg_mode      (cfg_mode),
    .dpram_rd_addr (dpram_rd_addr),
    .dpram_rd_data (dpram_rd_data),
    .m_if          (m_if),
    .err_clr       (err_clr),
    .err_len       (err_len),
    .err_overrun   (err_overrun),
    .xfer_cnt      (xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // DPRAM model: contents fixed by the bench, read data appears LAT cycles after the address
  logic [127:0] mem [LINES];
  logic [127:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[dpram_rd_addr];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign dpram_rd_data = rd_pipe[LAT-1];

  // Stream monitor: logs every handshake and counts stall-stability violations
  logic [15:0] hs_dat  [$];
  logic        hs_last [$];
  int          hs_cyc  [$];
  int          n_valid_cyc = 0;
  int          stab_bad = 0;
  logic        p_stall = 1'b0;
  logic [15:0] p_dat = '0;
  logic        p_last = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (m_if.m_valid) n_valid_cyc++;
      if (p_stall && (!m_if.m_valid || m_if.m_data !== p_dat || m_if.m_last !== p_last)) stab_bad++;
      if (m_if.m_valid && m_if.m_ready) begin
        hs_dat.push_back(m_if.m_data);
        hs_last.push_back(m_if.m_last);
        hs_cyc.push_back(cyc);
      end
      p_stall = m_if.m_valid && !m_if.m_ready;
      p_dat   = m_if.m_data;
      p_last  = m_if.m_last;
    end
  end

  // Reference model state
  int   exp_xfer = 0;
  logic exp_err_len = 1'b0;
  logic exp_err_ovr = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int i);
    logic [127:0] ln;
    ln = mem[i / WORDS_PER_LINE];
    return ln[16*(i % WORDS_PER_LINE) +: 16];
  endfunction

  task automatic run_xfer(input int len, input int rdy_pct, input bit inj_ovr,
                          input bit tog_mode, input int abort_at);
    int   n, t0, t_drop, busy_cyc, mode_bad, hs_base, val_base, stab_base, got_n;
    logic mode_exp;
    n         = (len > CAP) ? CAP : len;
    hs_base   = hs_dat.size();
    val_base  = n_valid_cyc;
    stab_base = stab_bad;
    @(posedge clk); #1;
    dpram_run     = 1'b1;
    dpram_len     = 16'(len);
    m_if.m_ready  = ($urandom_range(99) < rdy_pct);
    mode_exp      = cfg_mode;
    @(posedge clk); #1;
    dpram_run = 1'b0;
    t0 = cyc;
    if (len > CAP) exp_err_len = 1'b1;
    if (inj_ovr)   exp_err_ovr = 1'b1;
    t_drop = -1; busy_cyc = 0; mode_bad = 0;
    for (int i = 0; i < 20000 && t_drop < 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("busy_at_t1", dpram_busy, 1);
        if (n > 0) check("addr_at_t1", dpram_rd_addr, 0);
      end
      if (dpram_busy) begin
        busy_cyc++;
        if (dpram_mode !== mode_exp) mode_bad++;
      end else begin
        t_drop = cyc;
      end
      @(posedge clk); #1;
      m_if.m_ready = ($urandom_range(99) < rdy_pct);
      dpram_run    = inj_ovr && (i == 4);
      if (tog_mode && (i % 3 == 1)) cfg_mode = ~cfg_mode;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy",  dpram_busy, 0);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_last",  m_if.m_last, 0);
        check("rst_data",  m_if.m_data, 0);
        check("rst_addr",  dpram_rd_addr, 0);
        check("rst_xfer",  xfer_cnt, 0);
        check("rst_errs",  {err_len, err_overrun}, 0);
        check("rst_mode",  dpram_mode, 0);
        exp_xfer = 0; exp_err_len = 1'b0; exp_err_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
    end
    dpram_run = 1'b0;
    check("busy_drop_in_budget", t_drop >= 0, 1);
    got_n = hs_dat.size() - hs_base;
    check("word_count", got_n, n);
    for (int i = 0; i < got_n && i < n; i++) begin
      check($sformatf("data[%0d]", i), hs_dat[hs_base+i], model_word(i));
      check($sformatf("last[%0d]", i), hs_last[hs_base+i], (i == n - 1));
      if (rdy_pct >= 100)
        check($sformatf("hs_cycle[%0d]", i), hs_cyc[hs_base+i] - t0,
              LAT + 1 + i + (i / WORDS_PER_LINE) * (LAT + 1));
    end
    if (n == 0) begin
      check("zero_busy_cycles", busy_cyc, 1);
      check("zero_no_valid", n_valid_cyc - val_base, 0);
    end else if (rdy_pct >= 100) begin
      check("busy_drop_cycle", t_drop - t0,
            LAT + 1 + (n - 1) + ((n - 1) / WORDS_PER_LINE) * (LAT + 1) + 1);
    end
    if (n > 0) check("last_addr", dpram_rd_addr, (n - 1) / WORDS_PER_LINE);
    check("stall_stable", stab_bad - stab_base, 0);
    check("mode_frozen_busy", mode_bad, 0);
    exp_xfer++;
    check("xfer_cnt", xfer_cnt, exp_xfer);
    check("err_len", err_len, exp_err_len);
    check("err_overrun", err_overrun, exp_err_ovr);
    if (tog_mode) begin
      repeat (2) @(posedge clk);
      #1 check("mode_after_idle", dpram_mode, cfg_mode);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ln;
    m_if.m_ready = 1'b0;
    for (int a = 0; a < LINES; a++) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) ln[16*w +: 16] = 16'($urandom);
      mem[a] = ln;
    end
    for (int w = 0; w < WORDS_PER_LINE; w++) ln[16*w +: 16] = 16'(w);
    mem[0] = ln;

    #3;
    check("reset_busy",  dpram_busy, 0);
    check("reset_valid", m_if.m_valid, 0);
    check("reset_last",  m_if.m_last, 0);
    check("reset_addr",  dpram_rd_addr, 0);
    check("reset_xfer",  xfer_cnt, 0);
    check("reset_errs",  {err_len, err_overrun}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_xfer(8,      100, 1'b0, 1'b0, -1);
    run_xfer(11,     100, 1'b0, 1'b0, -1);
    run_xfer(20,      50, 1'b0, 1'b0, -1);
    run_xfer(0,      100, 1'b0, 1'b0, -1);
    run_xfer(16'hFFFF, 100, 1'b0, 1'b0, -1);

    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    exp_err_len = 1'b0; exp_err_ovr = 1'b0;
    check("err_len_cleared", err_len, exp_err_len);

    run_xfer(20,      70, 1'b1, 1'b0, -1);
    run_xfer(30,     100, 1'b0, 1'b1, -1);
    run_xfer(20,     100, 1'b0, 1'b0, 8);
    run_xfer(13,      60, 1'b0, 1'b0, -1);
    for (int k = 0; k < 6; k++)
      run_xfer($urandom_range(64, 1), $urandom_range(100, 30), 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wvb_dpram_drain.md
# wvb_dpram_drain

Consumer end of the waveform-reader DPRAM handshake. On a `dpram_run` pulse it asserts `dpram_busy`, reads `dpram_len` 16-bit words out of the 128-bit-wide DPRAM and serializes them onto a 16-bit valid/ready stream toward the MCU-facing FIFO. It releases `dpram_busy` when the transfer completes. It also owns and drives the `dpram_mode` configuration bit seen by the writer.

## Interface
Parameters:
- `P_DPRAM_ADR_WIDTH`, default 8: DPRAM line address width. Capacity is `8 * 2**P_DPRAM_ADR_WIDTH` words.
- `P_RD_LATENCY`, default 2: DPRAM read latency in cycles. Must be 1 or more.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `dpram_run`  in  1: one-cycle start pulse from the writer.
- `dpram_len`  in  16: number of valid 16-bit words. Sampled on `dpram_run`.
- `dpram_busy`  out  1: transfer in progress.
- `dpram_mode`  out  1: registered copy of `cfg_mode`. Stable while busy.
- `cfg_mode`  in  1: host configuration for `dpram_mode`.
- `dpram_rd_addr`  out  P_DPRAM_ADR_WIDTH: DPRAM read line address (registered).
- `dpram_rd_data`  in  128: DPRAM read data.
- `m_data`  out  16: stream word.
- `m_valid`  out  1: stream valid.
- `m_last`  out  1: final word of the transfer.
- `m_ready`  in  1: stream ready.
- `err_clr`  in  1: clears the sticky error flags.
- `err_len`  out  1: sticky; `dpram_len` exceeded capacity.
- `err_overrun`  out  1: sticky; `dpram_run` arrived while busy.
- `xfer_cnt`  out  32: count of completed transfers; wraps.

## Operation
- Reset value of every output is 0, applied asynchronously; no transfer is in flight after reset. A reset mid-transfer aborts it with no partial completion.
- States: S_IDLE, S_WAIT, S_STREAM, S_DONE.
- S_IDLE:
  - `dpram_busy`=0 and `dpram_mode` <= `cfg_mode`.
  - On `dpram_run`, latch `rem` = `dpram_len` and set `busy`=1.
  - If `rem`==0, go to S_DONE.
  - Otherwise set `dpram_rd_addr`=0, clear the wait counter and go to S_WAIT.
  - If `dpram_len` > capacity, clamp `rem` to capacity and set `err_len`.
- S_WAIT: count `P_RD_LATENCY` cycles, then capture `dpram_rd_data` into the line register, set `word_idx`=0 and `m_valid`=1, and go to S_STREAM.
- S_STREAM: `m_data` = line[16*word_idx +: 16], little-endian (word 0 = bits [15:0]). On `m_valid && m_ready`:
  - If `rem`==1: `m_valid`=0, `m_last`=0, `busy`=0, `xfer_cnt`++, go to S_IDLE.
  - Else if `word_idx`==7: `m_valid`=0, `dpram_rd_addr`++, go to S_WAIT.
  - Else: `word_idx`++.
  - In all cases `rem` is decremented.
  - `m_last`=1 exactly while `rem`==1 and `m_valid`=1.
- S_DONE (zero-length transfer only): `busy`=0, `xfer_cnt`++, go to S_IDLE.
- `dpram_run` while `busy` is ignored and sets `err_overrun`. `err_clr` clears both error flags; a simultaneous set wins.
- Stream rules: `m_data` and `m_last` are held stable while `m_valid && !m_ready`. `m_valid` never drops without a handshake.
- A clamped length that ends on the last line finishes at address `2**P_DPRAM_ADR_WIDTH-1`; the address never wraps.

## Timing
- `dpram_run` sampled at edge T: `busy`=1 and `dpram_rd_addr`=0 from T+1; first `m_valid` at T+2+`P_RD_LATENCY`.
- With `m_ready` held at 1: 8 words per line on consecutive cycles. The line boundary costs `P_RD_LATENCY`+1 bubble cycles.
- Last handshake at cycle C: `busy`=0, `m_valid`=0 and `xfer_cnt` updated at C+1. A new `dpram_run` is accepted from C+1.
- Zero length: `busy` is high for exactly one cycle (T+1 only), so the writer still observes busy→idle.
- `dpram_mode` changes only in S_IDLE, at most one cycle after `cfg_mode` changes.

## Structure
- Shared package `wvb_pkg`:
  - `DPRAM_LINE_W`=128, `STREAM_W`=16, `WORDS_PER_LINE`=8.
  - State encoding constants.
- Natural sub-module: `line_serializer`. It holds the 128-bit line register, `word_idx` and the 16-bit output select. The FSM, counters and error flags stay in the top level.

## Test plan
- `dpram_len`=8, `m_ready`=1, `P_RD_LATENCY`=2, line 0 = 0x0007_0006_…_0000 → `busy` at T+1, words 0x0000…0x0007 on T+4…T+11, `m_last` on 0x0007, `busy`=0 at T+12, `xfer_cnt`=1.
- `dpram_len`=11 → 8 words from address 0, then a 3-cycle bubble, then 3 words from address 1 bits [47:0]; `m_last` only on the 11th word.
- `dpram_len`=20 with `m_ready` random 50% → 20 words in order, data stable under backpressure, exactly one `m_last`.
- `dpram_len`=0 → `busy` high one cycle, no `m_valid`, `xfer_cnt` increments.
- `dpram_len`=0xFFFF (capacity 2048) → 2048 words, last address 255, `err_len`=1; `err_clr` → 0.
- `dpram_run` mid-transfer → ignored, `err_overrun`=1.
- `cfg_mode` toggled while busy → `dpram_mode` updates only after `busy` drops.
- `rst_n` low mid-stream → all outputs 0 immediately; the next run completes normally.
